// File: rtl/spi_master_sequencer.sv
// SPI master frame sequencer: frames fixed-length mode-0 transfers with cs setup/hold/idle gaps
// and a one-deep pending slot for starts that arrive mid-frame.
module spi_master_sequencer #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned SCLK_HALFPERIOD = 1,
  parameter int unsigned CS_SETUP        = 1,
  parameter int unsigned CS_HOLD         = 1,
  parameter int unsigned CS_IDLE         = 2,
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_transaction,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic          cs,
  output logic          sclk,
  output logic [BW-1:0] bit_index
);

  localparam int unsigned M1 = (SCLK_HALFPERIOD > CS_SETUP) ? SCLK_HALFPERIOD : CS_SETUP;
  localparam int unsigned M2 = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CMAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_n;
  logic          sclk_n, last, last_n, pending, pending_n;
  logic          done_n, overrun_n, cs_n, busy_n, consume;

  // Next-state, counters and next values of all registered outputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_index;
    sclk_n    = sclk;
    last_n    = last;
    pending_n = pending;
    done_n    = 1'b0;
    overrun_n = 1'b0;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n   = SETUP;
          cnt_n     = '0;
          pending_n = start_transaction;
        end else if (start_transaction) begin
          state_n = SETUP;
          cnt_n   = '0;
        end
      end
      SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sclk_n  = 1'b1;
          bit_n   = '0;
          last_n  = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == CW'(SCLK_HALFPERIOD - 1)) begin
          cnt_n = '0;
          if (sclk) begin
            // falling edge: advance bit, saturating on the final bit
            sclk_n = 1'b0;
            if (bit_index == BW'(DATA_WIDTH - 1)) last_n = 1'b1;
            else bit_n = bit_index + BW'(1);
          end else if (last) begin
            state_n = HOLD;
            bit_n   = '0;
            last_n  = 1'b0;
          end else begin
            sclk_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(CS_IDLE - 1)) begin
          cnt_n = '0;
          if (pending) begin
            state_n   = SETUP;
            pending_n = 1'b0;
            consume   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Mid-frame starts fill the pending slot; a full slot drops the request
    if (start_transaction && state != IDLE) begin
      if (consume || !pending) pending_n = 1'b1;
      else overrun_n = 1'b1;
    end
    cs_n   = (state_n == IDLE) || (state_n == GAP);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_index <= '0;
      sclk      <= 1'b0;
      last      <= 1'b0;
      pending   <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      cs        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_index <= bit_n;
      sclk      <= sclk_n;
      last      <= last_n;
      pending   <= pending_n;
      done      <= done_n;
      overrun   <= overrun_n;
      cs        <= cs_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer: three configurations, per-cycle traces checked
// against hand-computed frame timing.
module tb_spi_master_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;

  logic busy_a, done_a, ovr_a, cs_a, sclk_a;
  logic [2:0] bi_a;
  logic busy_b, done_b, ovr_b, cs_b, sclk_b;
  logic [2:0] bi_b;
  logic busy_c, done_c, ovr_c, cs_c, sclk_c;
  logic [0:0] bi_c;

  logic st_a, st_b, st_c;
  assign st_a = start && (sel == 0);
  assign st_b = start && (sel == 1);
  assign st_c = start && (sel == 2);

  spi_master_sequencer #(.DATA_WIDTH(8), .SCLK_HALFPERIOD(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_a (
    .clk(clk), .rst(rst), .start_transaction(st_a), .busy(busy_a), .done(done_a),
    .overrun(ovr_a), .cs(cs_a), .sclk(sclk_a), .bit_index(bi_a));
  spi_master_sequencer #(.DATA_WIDTH(8), .SCLK_HALFPERIOD(3), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_b (
    .clk(clk), .rst(rst), .start_transaction(st_b), .busy(busy_b), .done(done_b),
    .overrun(ovr_b), .cs(cs_b), .sclk(sclk_b), .bit_index(bi_b));
  spi_master_sequencer #(.DATA_WIDTH(1), .SCLK_HALFPERIOD(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_c (
    .clk(clk), .rst(rst), .start_transaction(st_c), .busy(busy_c), .done(done_c),
    .overrun(ovr_c), .cs(cs_c), .sclk(sclk_c), .bit_index(bi_c));

  always #5 clk = ~clk;

  int o_cs, o_sclk, o_busy, o_done, o_ovr, o_bi;
  always_comb begin
    case (sel)
      1: begin o_cs = int'(cs_b); o_sclk = int'(sclk_b); o_busy = int'(busy_b);
               o_done = int'(done_b); o_ovr = int'(ovr_b); o_bi = int'(bi_b); end
      2: begin o_cs = int'(cs_c); o_sclk = int'(sclk_c); o_busy = int'(busy_c);
               o_done = int'(done_c); o_ovr = int'(ovr_c); o_bi = int'(bi_c); end
      default: begin o_cs = int'(cs_a); o_sclk = int'(sclk_a); o_busy = int'(busy_a);
               o_done = int'(done_a); o_ovr = int'(ovr_a); o_bi = int'(bi_a); end
    endcase
  end

  int cs_t[0:127], sclk_t[0:127], busy_t[0:127], done_t[0:127], ovr_t[0:127], bi_t[0:127];
  int start_at[0:127];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_starts();
    for (int k = 0; k < 128; k++) start_at[k] = 0;
  endtask

  // Sample cycles 0..n (cycle 0 = now, 1 ns after an edge), driving start per schedule
  task automatic run(input int n);
    for (int k = 0; k <= n; k++) begin
      cs_t[k] = o_cs; sclk_t[k] = o_sclk; busy_t[k] = o_busy;
      done_t[k] = o_done; ovr_t[k] = o_ovr; bi_t[k] = o_bi;
      start = (start_at[k] != 0);
      if (k < n) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  function automatic int n_low(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (cs_t[k] == 0) c++;
    return c;
  endfunction

  function automatic int first_low(input int n);
    for (int k = 0; k <= n; k++) if (cs_t[k] == 0) return k;
    return -1;
  endfunction

  function automatic int last_low(input int n);
    int r = -1;
    for (int k = 0; k <= n; k++) if (cs_t[k] == 0) r = k;
    return r;
  endfunction

  function automatic int n_rise(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (sclk_t[k] == 1 && sclk_t[k-1] == 0) c++;
    return c;
  endfunction

  function automatic int first_rise(input int n);
    for (int k = 1; k <= n; k++) if (sclk_t[k] == 1 && sclk_t[k-1] == 0) return k;
    return -1;
  endfunction

  function automatic int n_done(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) c += done_t[k];
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k <= n; k++) if (done_t[k] == 1) return k;
    return -1;
  endfunction

  function automatic int n_ovr(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) c += ovr_t[k];
    return c;
  endfunction

  function automatic int max_bi(input int n);
    int m = 0;
    for (int k = 0; k <= n; k++) if (bi_t[k] > m) m = bi_t[k];
    return m;
  endfunction

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 0;
    chk("rst_cs", o_cs, 1);
    chk("rst_sclk", o_sclk, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovr", o_ovr, 0);
    chk("rst_bi", o_bi, 0);

    // single frame, DW=8, half=1
    clear_starts(); start_at[0] = 1;
    run(25);
    chk("t1_cs_low_cnt", n_low(25), 18);
    chk("t1_cs_first", first_low(25), 1);
    chk("t1_cs_last", last_low(25), 18);
    chk("t1_rises", n_rise(25), 8);
    chk("t1_first_rise", first_rise(25), 2);
    chk("t1_sclk16", sclk_t[16], 1);
    chk("t1_sclk17", sclk_t[17], 0);
    chk("t1_done_cyc", first_done(25), 19);
    chk("t1_done_cnt", n_done(25), 1);
    chk("t1_busy1", busy_t[1], 1);
    chk("t1_busy20", busy_t[20], 1);
    chk("t1_busy21", busy_t[21], 0);
    chk("t1_bi2", bi_t[2], 0);
    chk("t1_bi3", bi_t[3], 1);
    chk("t1_bi17", bi_t[17], 7);
    chk("t1_bi18", bi_t[18], 0);

    // half period 3
    sel = 1;
    clear_starts(); start_at[0] = 1;
    run(60);
    chk("t2_cs_low_cnt", n_low(60), 50);
    chk("t2_cs_last", last_low(60), 50);
    chk("t2_rises", n_rise(60), 8);
    chk("t2_sclk2", sclk_t[2], 1);
    chk("t2_sclk4", sclk_t[4], 1);
    chk("t2_sclk5", sclk_t[5], 0);
    chk("t2_sclk7", sclk_t[7], 0);
    chk("t2_sclk8", sclk_t[8], 1);
    chk("t2_bi5", bi_t[5], 1);
    chk("t2_bi41", bi_t[41], 7);
    chk("t2_bi49", bi_t[49], 7);
    chk("t2_bi_max", max_bi(60), 7);
    chk("t2_done_cyc", first_done(60), 51);
    chk("t2_busy53", busy_t[53], 0);

    // back-to-back via pending slot
    sel = 0;
    clear_starts(); start_at[0] = 1; start_at[5] = 1;
    run(45);
    chk("t3_cs19", cs_t[19], 1);
    chk("t3_cs20", cs_t[20], 1);
    chk("t3_cs21", cs_t[21], 0);
    chk("t3_cs_low_cnt", n_low(45), 36);
    chk("t3_done_cnt", n_done(45), 2);
    chk("t3_done2", done_t[39], 1);
    chk("t3_ovr_cnt", n_ovr(45), 0);
    chk("t3_busy20", busy_t[20], 1);
    chk("t3_busy41", busy_t[41], 0);

    // third start overruns
    clear_starts(); start_at[0] = 1; start_at[5] = 1; start_at[7] = 1;
    run(45);
    chk("t4_ovr8", ovr_t[8], 1);
    chk("t4_ovr_cnt", n_ovr(45), 1);
    chk("t4_done_cnt", n_done(45), 2);
    chk("t4_cs_low_cnt", n_low(45), 36);

    // async reset mid-SHIFT
    clear_starts(); start_at[0] = 1;
    run(10);
    chk("t5_pre_cs", o_cs, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_cs", o_cs, 1);
    chk("t5_rst_sclk", o_sclk, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_bi", o_bi, 0);
    @(posedge clk);
    #1;
    clear_starts();
    run(3);
    rst = 1'b0;
    run(4);
    chk("t5_no_done", n_done(4), 0);
    chk("t5_idle_cs", n_low(4), 0);
    clear_starts(); start_at[0] = 1;
    run(25);
    chk("t5_cs_low_cnt", n_low(25), 18);
    chk("t5_done_cyc", first_done(25), 19);

    // single-bit frame
    sel = 2;
    clear_starts(); start_at[0] = 1;
    run(10);
    chk("t6_cs_low_cnt", n_low(10), 4);
    chk("t6_cs_first", first_low(10), 1);
    chk("t6_rises", n_rise(10), 1);
    chk("t6_first_rise", first_rise(10), 2);
    chk("t6_bi_max", max_bi(10), 0);
    chk("t6_done_cyc", first_done(10), 5);
    chk("t6_busy6", busy_t[6], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
